// File: rtl/mul_pkg.sv
// mul_pkg: shared definitions for the multiplier arbiter slice.
//   - state_t    : sequencer state encoding (IDLE, ARRANCA, ESPERA, ENTREGA)
//   - N_REQ_DEF  : default requester count
//   - WIDTH_DEF  : default operand width
//   - PROD_W_DEF : default product width (2*WIDTH_DEF)
//   - prod_w()   : product width for an arbitrary operand width
package mul_pkg;

    localparam int N_REQ_DEF  = 4;
    localparam int WIDTH_DEF  = 3;
    localparam int PROD_W_DEF = 2 * WIDTH_DEF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARRANCA = 2'd1,
        ESPERA  = 2'd2,
        ENTREGA = 2'd3
    } state_t;

    function automatic int prod_w(input int w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/mul_arbitro_rr_selector.sv
// rr_selector: combinational round-robin picker.
// Ports:
//   req   [N_REQ-1:0] : request vector
//   ptr   [IW-1:0]    : index of the last-served requester
//   win   [N_REQ-1:0] : one-hot winner (zero when nothing is requested)
//   index [IW-1:0]    : binary index of the winner
//   any               : at least one request is pending
// The scan starts at ptr+1 and wraps modulo N_REQ, so the last-served
// requester is visited last.
module rr_selector #(
    parameter int N_REQ = 4,
    parameter int IW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] win,
    output logic [IW-1:0]    index,
    output logic             any
);

    always_comb begin
        int j;
        j     = 0;
        win   = '0;
        index = '0;
        any   = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            j = (int'(ptr) + k) % N_REQ;
            if (!any && req[j]) begin
                any    = 1'b1;
                win[j] = 1'b1;
                index  = IW'(j);
            end
        end
    end

endmodule

// File: rtl/mul_arbitro.sv
// mul_arbitro: round-robin arbiter/sequencer sharing one start/Fin
// handshaked multiplier between N_REQ requesters.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   req               : level request per requester, held until its gnt
//   op_a, op_b        : packed operands, entry i belongs to requester i
//   gnt               : one-hot pulse, operands of that requester captured
//   done_out          : one-hot pulse, res_out valid for that requester
//   res_out           : product while done_out != 0, else 0
//   busy              : high in any state except IDLE
//   err_out           : abort flag, qualified by done_out
//   mul_start         : one-cycle start pulse to the multiplier
//   mul_a, mul_b      : captured operands, stable ARRANCA..ENTREGA
//   mul_fin           : multiplier Fin
//   mul_result        : multiplier product, valid with mul_fin
// Optional feature: define MUL_TIMEOUT_EN to abort a transaction after
// TIMEOUT cycles in ESPERA without mul_fin (done_out with err_out=1,
// res_out=0). Undefined: ESPERA waits indefinitely and err_out is 0.
// All outputs are registered inside the single FSM process.
module mul_arbitro
    import mul_pkg::*;
#(
    parameter int N_REQ   = N_REQ_DEF,
    parameter int WIDTH   = WIDTH_DEF,
    parameter int TIMEOUT = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ-1:0][WIDTH-1:0] op_a,
    input  logic [N_REQ-1:0][WIDTH-1:0] op_b,
    output logic [N_REQ-1:0]            gnt,
    output logic [N_REQ-1:0]            done_out,
    output logic [2*WIDTH-1:0]          res_out,
    output logic                        busy,
    output logic                        err_out,
    output logic                        mul_start,
    output logic [WIDTH-1:0]            mul_a,
    output logic [WIDTH-1:0]            mul_b,
    input  logic                        mul_fin,
    input  logic [2*WIDTH-1:0]          mul_result
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    if (N_REQ < 2 || TIMEOUT < 1) begin : g_bad_params
        $error("mul_arbitro: N_REQ must be >= 2 and TIMEOUT >= 1");
    end

    state_t           state;
    logic [IW-1:0]    owner;
    logic [N_REQ-1:0] owner_oh;
    logic [IW-1:0]    ptr;

    logic [N_REQ-1:0] win;
    logic [IW-1:0]    win_idx;
    logic             win_any;

`ifdef MUL_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
    logic          err_q;
    assign err_out = err_q;
`else
    assign err_out = 1'b0;
`endif

    rr_selector #(.N_REQ(N_REQ), .IW(IW)) u_sel (
        .req   (req),
        .ptr   (ptr),
        .win   (win),
        .index (win_idx),
        .any   (win_any)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            owner     <= '0;
            owner_oh  <= '0;
            ptr       <= IW'(N_REQ - 1);  // requester 0 wins first
            gnt       <= '0;
            done_out  <= '0;
            res_out   <= '0;
            busy      <= 1'b0;
            mul_start <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
`ifdef MUL_TIMEOUT_EN
            cnt       <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (win_any) begin
                        owner     <= win_idx;
                        owner_oh  <= win;
                        mul_a     <= op_a[win_idx];
                        mul_b     <= op_b[win_idx];
                        gnt       <= win;
                        mul_start <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ARRANCA;
                    end
                end
                ARRANCA: begin
                    // mul_fin is deliberately not looked at here
                    gnt       <= '0;
                    mul_start <= 1'b0;
                    state     <= ESPERA;
`ifdef MUL_TIMEOUT_EN
                    cnt       <= '0;
`endif
                end
                ESPERA: begin
                    // mul_fin has priority over a timeout in the same cycle
                    if (mul_fin) begin
                        res_out  <= mul_result;
                        done_out <= owner_oh;
                        state    <= ENTREGA;
                    end
`ifdef MUL_TIMEOUT_EN
                    else if (cnt == CW'(TIMEOUT - 1)) begin
                        res_out  <= '0;
                        done_out <= owner_oh;
                        err_q    <= 1'b1;
                        state    <= ENTREGA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                ENTREGA: begin
                    done_out <= '0;
                    res_out  <= '0;
                    ptr      <= owner;
                    busy     <= 1'b0;
                    state    <= IDLE;
`ifdef MUL_TIMEOUT_EN
                    err_q    <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_arbitro.sv
// tb_mul_arbitro: directed, table-driven bench for mul_arbitro with a
// bench-side multiplier stand-in (mul_fin/mul_result driven by hand).
module tb_mul_arbitro;

    logic            clk = 1'b0;
    logic            reset;
    logic [3:0]      req;
    logic [3:0][2:0] op_a, op_b;
    logic [3:0]      gnt, done_out;
    logic [5:0]      res_out;
    logic            busy, err_out, mul_start;
    logic [2:0]      mul_a, mul_b;
    logic            mul_fin;
    logic [5:0]      mul_result;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    mul_arbitro #(.N_REQ(4), .WIDTH(3), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .req(req), .op_a(op_a), .op_b(op_b),
        .gnt(gnt), .done_out(done_out), .res_out(res_out), .busy(busy),
        .err_out(err_out), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_fin(mul_fin), .mul_result(mul_result)
    );

    typedef struct {
        logic [3:0]      req;
        logic [3:0][2:0] a;
        logic [3:0][2:0] b;
        int              dly;   // ESPERA cycle in which mul_fin is raised
        logic [5:0]      prod;
        logic [3:0]      exp_gnt;
        logic [2:0]      exp_a;
        logic [2:0]      exp_b;
    } vec_t;

    vec_t tv[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, ".gnt"},  32'(gnt), 0);
        chk({nm, ".done"}, 32'(done_out), 0);
        chk({nm, ".res"},  32'(res_out), 0);
        chk({nm, ".busy"}, 32'(busy), 0);
        chk({nm, ".err"},  32'(err_out), 0);
        chk({nm, ".start"}, 32'(mul_start), 0);
        chk({nm, ".mul_a"}, 32'(mul_a), 0);
        chk({nm, ".mul_b"}, 32'(mul_b), 0);
    endtask

    initial begin
        // {req, a3..a0, b3..b0, dly, prod, gnt, mul_a, mul_b}
        tv[0] = '{4'b0001, {3'd0,3'd0,3'd0,3'd3}, {3'd0,3'd0,3'd0,3'd2}, 4, 6'd6,  4'b0001, 3'd3, 3'd2};
        tv[1] = '{4'b0010, {3'd0,3'd0,3'd5,3'd0}, {3'd0,3'd0,3'd1,3'd0}, 1, 6'd5,  4'b0010, 3'd5, 3'd1};
        tv[2] = '{4'b1010, {3'd2,3'd0,3'd7,3'd0}, {3'd3,3'd0,3'd7,3'd0}, 3, 6'd6,  4'b1000, 3'd2, 3'd3};
        tv[3] = '{4'b1010, {3'd2,3'd0,3'd7,3'd0}, {3'd3,3'd0,3'd7,3'd0}, 2, 6'd49, 4'b0010, 3'd7, 3'd7};
        tv[4] = '{4'b0101, {3'd0,3'd6,3'd0,3'd1}, {3'd0,3'd2,3'd0,3'd4}, 1, 6'd12, 4'b0100, 3'd6, 3'd2};
        tv[5] = '{4'b0101, {3'd0,3'd6,3'd0,3'd1}, {3'd0,3'd2,3'd0,3'd4}, 2, 6'd4,  4'b0001, 3'd1, 3'd4};

        reset = 1'b1; req = '0; op_a = '0; op_b = '0; mul_fin = 1'b0; mul_result = '0;
        tick(); tick();
        chk_all_zero("reset");
        reset = 1'b0;
        tick();
        chk("idle_busy", 32'(busy), 0);

        // all four requesting, held: order 0,1,2,3,0
        req = 4'b1111;
        op_a = {3'd4, 3'd3, 3'd2, 3'd1};
        op_b = {3'd1, 3'd1, 3'd1, 3'd1};
        for (int i = 0; i < 5; i++) begin
            logic [3:0] eg;
            eg = 4'(1 << (i % 4));
            tick();
            chk("rr.gnt", 32'(gnt), 32'(eg));
            chk("rr.mul_a", 32'(mul_a), 32'((i % 4) + 1));
            tick();
            mul_fin = 1'b1; mul_result = 6'(i + 10);
            tick();
            chk("rr.done", 32'(done_out), 32'(eg));
            chk("rr.res", 32'(res_out), 32'(i + 10));
            mul_fin = 1'b0; mul_result = '0;
            tick();
            chk("rr.idle_gnt", 32'(gnt), 0);
            chk("rr.idle_busy", 32'(busy), 0);
        end
        req = '0;
        tick();

        // table-driven single transactions (DUT is idle at each start)
        for (int v = 0; v < 6; v++) begin
            req = tv[v].req; op_a = tv[v].a; op_b = tv[v].b;
            tick();
            chk($sformatf("v%0d.gnt", v),   32'(gnt), 32'(tv[v].exp_gnt));
            chk($sformatf("v%0d.start", v), 32'(mul_start), 1);
            chk($sformatf("v%0d.mul_a", v), 32'(mul_a), 32'(tv[v].exp_a));
            chk($sformatf("v%0d.mul_b", v), 32'(mul_b), 32'(tv[v].exp_b));
            chk($sformatf("v%0d.busy", v),  32'(busy), 1);
            req = '0;
            tick();
            chk($sformatf("v%0d.esp_gnt", v),   32'(gnt), 0);
            chk($sformatf("v%0d.esp_start", v), 32'(mul_start), 0);
            repeat (tv[v].dly - 1) tick();
            chk($sformatf("v%0d.esp_done", v), 32'(done_out), 0);
            mul_fin = 1'b1; mul_result = tv[v].prod;
            tick();
            chk($sformatf("v%0d.done", v),  32'(done_out), 32'(tv[v].exp_gnt));
            chk($sformatf("v%0d.res", v),   32'(res_out), 32'(tv[v].prod));
            chk($sformatf("v%0d.err", v),   32'(err_out), 0);
            chk($sformatf("v%0d.hold_a", v), 32'(mul_a), 32'(tv[v].exp_a));
            mul_fin = 1'b0; mul_result = '0;
            tick();
            chk($sformatf("v%0d.post_done", v), 32'(done_out), 0);
            chk($sformatf("v%0d.post_res", v),  32'(res_out), 0);
            chk($sformatf("v%0d.post_busy", v), 32'(busy), 0);
        end

        // early fin during ARRANCA is ignored; signed product passes through
        req = 4'b1000; op_a = {3'b101, 9'd0}; op_b = {3'b010, 9'd0};
        tick();
        chk("early.gnt", 32'(gnt), 32'(4'b1000));
        req = '0; mul_fin = 1'b1; mul_result = 6'h15;
        tick();
        mul_fin = 1'b0; mul_result = '0;
        chk("early.no_done", 32'(done_out), 0);
        chk("early.busy", 32'(busy), 1);
        tick();
        chk("early.still_wait", 32'(done_out), 0);
        mul_fin = 1'b1; mul_result = 6'b111010;
        tick();
        chk("signed.done", 32'(done_out), 32'(4'b1000));
        chk("signed.res", 32'(res_out), 32'(6'b111010));
        mul_fin = 1'b0; mul_result = '0;
        tick();

        // reset in ESPERA: outputs clear at once, then requester 2 served
        req = 4'b0001; op_a = {9'd0, 3'd5}; op_b = {9'd0, 3'd5};
        tick();
        req = '0;
        tick(); tick();
        chk("mid.busy_before", 32'(busy), 1);
        reset = 1'b1;
        #1;
        chk_all_zero("midrst");
        tick();
        reset = 1'b0;
        req = 4'b0100; op_a = {3'd0, 3'd3, 6'd0}; op_b = {3'd0, 3'd3, 6'd0};
        tick();
        chk("after_rst.gnt", 32'(gnt), 32'(4'b0100));
        chk("after_rst.mul_a", 32'(mul_a), 3);
        req = '0;
        tick();
        mul_fin = 1'b1; mul_result = 6'd9;
        tick();
        chk("after_rst.done", 32'(done_out), 32'(4'b0100));
        chk("after_rst.res", 32'(res_out), 9);
        mul_fin = 1'b0; mul_result = '0;
        tick();

        // no mul_fin: timeout after 16 ESPERA cycles, or wait forever
        req = 4'b0010; op_a = {3'd0, 3'd0, 3'd2, 3'd0}; op_b = {3'd0, 3'd0, 3'd2, 3'd0};
        tick();
        req = '0;
        tick();                 // ESPERA cycle 1
        repeat (15) tick();     // ESPERA cycle 16
        chk("to.cycle16_done", 32'(done_out), 0);
        chk("to.cycle16_busy", 32'(busy), 1);
`ifdef MUL_TIMEOUT_EN
        tick();
        chk("to.done", 32'(done_out), 32'(4'b0010));
        chk("to.err", 32'(err_out), 1);
        chk("to.res", 32'(res_out), 0);
        tick();
        chk("to.post_err", 32'(err_out), 0);
        chk("to.post_busy", 32'(busy), 0);
        // fin on the very cycle the count expires wins
        req = 4'b0010;
        tick();
        req = '0;
        tick();
        repeat (15) tick();
        mul_fin = 1'b1; mul_result = 6'd4;
        tick();
        chk("tofin.done", 32'(done_out), 32'(4'b0010));
        chk("tofin.err", 32'(err_out), 0);
        chk("tofin.res", 32'(res_out), 4);
        mul_fin = 1'b0; mul_result = '0;
        tick();
`else
        repeat (8) tick();
        chk("nto.busy", 32'(busy), 1);
        chk("nto.done", 32'(done_out), 0);
        chk("nto.err", 32'(err_out), 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
